// File: rtl/sc_game_pkg.sv
// Shared definitions for the Frogger game-status slice: FSM encoding,
// LastRegister status codes and default game dimensions.
package sc_game_pkg;

  localparam int LIVES_INIT_DEF = 3;
  localparam int LEVEL_MAX_DEF  = 4;
  localparam int HOUSES_DEF     = 5;
  localparam int LIVES_W_DEF    = $clog2(LIVES_INIT_DEF + 1);
  localparam int LEVEL_W_DEF    = $clog2(LEVEL_MAX_DEF + 1);

  localparam logic [1:0] LASTREG_LEVELDONE = 2'b00;
  localparam logic [1:0] LASTREG_HOUSE     = 2'b10;
  localparam logic [1:0] LASTREG_IDLE      = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_HOUSE_PEND,
    ST_FROZEN
  } statusState_t;

endpackage

// File: rtl/sc_gamestatus_if.sv
// Command/status bundle between the game state machine (master) and the
// game-status datapath (slave). Command strobes are active-low.
interface sc_gamestatus_if
  import sc_game_pkg::*;
#(
  parameter int HOUSES  = HOUSES_DEF,
  parameter int LIVES_W = LIVES_W_DEF,
  parameter int LEVEL_W = LEVEL_W_DEF
);
  logic               SC_GAMESTATUS_StartGame_InLow;
  logic               SC_GAMESTATUS_ClearLost_InLow;
  logic               SC_GAMESTATUS_LifesSignal_InLow;
  logic               SC_GAMESTATUS_LoadLastRegister_InLow;
  logic               SC_GAMESTATUS_LoadGame_InLow;
  logic               SC_GAMESTATUS_Collision_InLow;
  logic [HOUSES-1:0]  SC_GAMESTATUS_FrogTopRow_InBUS;
  logic               SC_GAMESTATUS_MatrixComparator_OutLow;
  logic               SC_GAMESTATUS_LifesCounterComparator_OutLow;
  logic               SC_GAMESTATUS_LevelCounterComparator_OutLow;
  logic [1:0]         SC_GAMESTATUS_LastRegister_OutBUS;
  logic [LIVES_W-1:0] SC_GAMESTATUS_Lives_OutBUS;
  logic [LEVEL_W-1:0] SC_GAMESTATUS_Level_OutBUS;
  logic [HOUSES-1:0]  SC_GAMESTATUS_Houses_OutBUS;

  modport master (
    output SC_GAMESTATUS_StartGame_InLow, SC_GAMESTATUS_ClearLost_InLow,
           SC_GAMESTATUS_LifesSignal_InLow, SC_GAMESTATUS_LoadLastRegister_InLow,
           SC_GAMESTATUS_LoadGame_InLow, SC_GAMESTATUS_Collision_InLow,
           SC_GAMESTATUS_FrogTopRow_InBUS,
    input  SC_GAMESTATUS_MatrixComparator_OutLow, SC_GAMESTATUS_LifesCounterComparator_OutLow,
           SC_GAMESTATUS_LevelCounterComparator_OutLow, SC_GAMESTATUS_LastRegister_OutBUS,
           SC_GAMESTATUS_Lives_OutBUS, SC_GAMESTATUS_Level_OutBUS, SC_GAMESTATUS_Houses_OutBUS
  );

  modport slave (
    input  SC_GAMESTATUS_StartGame_InLow, SC_GAMESTATUS_ClearLost_InLow,
           SC_GAMESTATUS_LifesSignal_InLow, SC_GAMESTATUS_LoadLastRegister_InLow,
           SC_GAMESTATUS_LoadGame_InLow, SC_GAMESTATUS_Collision_InLow,
           SC_GAMESTATUS_FrogTopRow_InBUS,
    output SC_GAMESTATUS_MatrixComparator_OutLow, SC_GAMESTATUS_LifesCounterComparator_OutLow,
           SC_GAMESTATUS_LevelCounterComparator_OutLow, SC_GAMESTATUS_LastRegister_OutBUS,
           SC_GAMESTATUS_Lives_OutBUS, SC_GAMESTATUS_Level_OutBUS, SC_GAMESTATUS_Houses_OutBUS
  );
endinterface

// File: rtl/sc_satcounter.sv
// Loadable up/down counter that saturates at zero and at a supplied maximum.
module sc_satcounter #(
  parameter int WIDTH = 4
) (
  input  logic             SC_SATCOUNTER_CLOCK_50,
  input  logic             SC_SATCOUNTER_RESET_InLow,
  input  logic             SC_SATCOUNTER_Load_InHigh,
  input  logic [WIDTH-1:0] SC_SATCOUNTER_LoadValue_InBUS,
  input  logic             SC_SATCOUNTER_Enable_InHigh,
  input  logic             SC_SATCOUNTER_CountUp_InHigh,
  input  logic [WIDTH-1:0] SC_SATCOUNTER_MaxValue_InBUS,
  output logic [WIDTH-1:0] SC_SATCOUNTER_Count_OutBUS
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge SC_SATCOUNTER_CLOCK_50 or negedge SC_SATCOUNTER_RESET_InLow) begin
    if (!SC_SATCOUNTER_RESET_InLow) begin
      count <= '0;
    end else if (SC_SATCOUNTER_Load_InHigh) begin
      count <= SC_SATCOUNTER_LoadValue_InBUS;
    end else if (SC_SATCOUNTER_Enable_InHigh) begin
      if (SC_SATCOUNTER_CountUp_InHigh) begin
        if (count < SC_SATCOUNTER_MaxValue_InBUS) count <= count + WIDTH'(1);
      end else begin
        if (count != '0) count <= count - WIDTH'(1);
      end
    end
  end

  assign SC_SATCOUNTER_Count_OutBUS = count;

endmodule

// File: rtl/sc_gamestatus.sv
// Frogger game-status datapath: executes the state machine's active-low
// strobes and reports lives/level/goal-row status, all decoded from registers.
module sc_gamestatus
  import sc_game_pkg::*;
#(
  parameter int LIVES_INIT = LIVES_INIT_DEF,
  parameter int LEVEL_MAX  = LEVEL_MAX_DEF,
  parameter int HOUSES     = HOUSES_DEF
) (
  input  logic           SC_GAMESTATUS_CLOCK_50,
  input  logic           SC_GAMESTATUS_RESET_InLow,
  sc_gamestatus_if.slave bus
);

  localparam int LIVES_W = $clog2(LIVES_INIT + 1);
  localparam int LEVEL_W = $clog2(LEVEL_MAX + 1);
  localparam logic [HOUSES-1:0] ALL_HOUSES = '1;

  function automatic logic isOneHot(input logic [HOUSES-1:0] v);
    return (v != '0) && ((v & (v - HOUSES'(1))) == '0);
  endfunction

  statusState_t      state;
  logic [HOUSES-1:0] houses;
  logic [HOUSES-1:0] slot;
  logic              lost;
  logic              armed;
  logic [LIVES_W-1:0] lives;
  logic [LEVEL_W-1:0] level;

  logic [HOUSES-1:0] frog;
  logic              collisionN;
  assign frog       = bus.SC_GAMESTATUS_FrogTopRow_InBUS;
  assign collisionN = bus.SC_GAMESTATUS_Collision_InLow;

  // Only the highest-priority low strobe is decoded; the rest are masked.
  logic cmdStart, cmdClear, cmdLife, cmdHouse, cmdLevel, cmdAny;
  assign cmdStart = ~bus.SC_GAMESTATUS_StartGame_InLow;
  assign cmdClear = ~cmdStart & ~bus.SC_GAMESTATUS_ClearLost_InLow;
  assign cmdLife  = ~cmdStart & ~cmdClear & ~bus.SC_GAMESTATUS_LifesSignal_InLow;
  assign cmdHouse = ~cmdStart & ~cmdClear & ~cmdLife & ~bus.SC_GAMESTATUS_LoadLastRegister_InLow;
  assign cmdLevel = ~cmdStart & ~cmdClear & ~cmdLife & ~cmdHouse & ~bus.SC_GAMESTATUS_LoadGame_InLow;
  assign cmdAny   = cmdStart | cmdClear | cmdLife | cmdHouse | cmdLevel;

  logic lifeGo, levelGo, capture;
  assign lifeGo  = cmdLife && (state != ST_FROZEN);
  assign levelGo = cmdLevel && (state == ST_PLAY) && (houses == ALL_HOUSES)
                   && (level < LEVEL_W'(LEVEL_MAX));
  assign capture = !cmdAny && (state == ST_PLAY) && armed && !lost && collisionN
                   && isOneHot(frog) && ((frog & houses) == '0);

  sc_satcounter #(.WIDTH(LIVES_W)) livesCounter (
    .SC_SATCOUNTER_CLOCK_50        (SC_GAMESTATUS_CLOCK_50),
    .SC_SATCOUNTER_RESET_InLow     (SC_GAMESTATUS_RESET_InLow),
    .SC_SATCOUNTER_Load_InHigh     (cmdStart),
    .SC_SATCOUNTER_LoadValue_InBUS (LIVES_W'(LIVES_INIT)),
    .SC_SATCOUNTER_Enable_InHigh   (lifeGo),
    .SC_SATCOUNTER_CountUp_InHigh  (1'b0),
    .SC_SATCOUNTER_MaxValue_InBUS  (LIVES_W'(LIVES_INIT)),
    .SC_SATCOUNTER_Count_OutBUS    (lives)
  );

  sc_satcounter #(.WIDTH(LEVEL_W)) levelCounter (
    .SC_SATCOUNTER_CLOCK_50        (SC_GAMESTATUS_CLOCK_50),
    .SC_SATCOUNTER_RESET_InLow     (SC_GAMESTATUS_RESET_InLow),
    .SC_SATCOUNTER_Load_InHigh     (cmdStart),
    .SC_SATCOUNTER_LoadValue_InBUS ('0),
    .SC_SATCOUNTER_Enable_InHigh   (levelGo),
    .SC_SATCOUNTER_CountUp_InHigh  (1'b1),
    .SC_SATCOUNTER_MaxValue_InBUS  (LEVEL_W'(LEVEL_MAX)),
    .SC_SATCOUNTER_Count_OutBUS    (level)
  );

  always_ff @(posedge SC_GAMESTATUS_CLOCK_50 or negedge SC_GAMESTATUS_RESET_InLow) begin
    if (!SC_GAMESTATUS_RESET_InLow) begin
      state  <= ST_IDLE;
      houses <= '0;
      lost   <= 1'b0;
      armed  <= 1'b0;
    end else if (cmdStart) begin
      state  <= ST_PLAY;
      houses <= '0;
      lost   <= 1'b0;
      armed  <= 1'b0;
    end else if (cmdClear) begin
      state <= ST_FROZEN;
    end else if (cmdLife) begin
      if (state != ST_FROZEN) begin
        lost  <= 1'b0;
        armed <= 1'b0;
        state <= ST_PLAY;
      end
    end else if (cmdHouse) begin
      if (state == ST_HOUSE_PEND) begin
        houses <= houses | slot;
        armed  <= 1'b0;
        state  <= ST_PLAY;
      end
    end else if (cmdLevel) begin
      if (levelGo) begin
        houses <= '0;
        armed  <= 1'b0;
      end
    end else if (state == ST_PLAY) begin
      // A fresh frog must be seen clear of the goal row and hazards before it can score or die.
      if (!armed) begin
        if (frog == '0 && collisionN) armed <= 1'b1;
      end else if (!lost) begin
        if (!collisionN)       lost  <= 1'b1;
        else if (capture)      state <= ST_HOUSE_PEND;
        else if (frog != '0)   lost  <= 1'b1;
      end
    end
  end

  always_ff @(posedge SC_GAMESTATUS_CLOCK_50) begin
    if (capture) slot <= frog;
  end

  assign bus.SC_GAMESTATUS_MatrixComparator_OutLow       = ~lost;
  assign bus.SC_GAMESTATUS_LifesCounterComparator_OutLow = ~((state != ST_IDLE) && (lives == '0));
  assign bus.SC_GAMESTATUS_LevelCounterComparator_OutLow = ~(level == LEVEL_W'(LEVEL_MAX));
  assign bus.SC_GAMESTATUS_LastRegister_OutBUS =
      (houses == ALL_HOUSES)     ? LASTREG_LEVELDONE :
      (state == ST_HOUSE_PEND)   ? LASTREG_HOUSE     : LASTREG_IDLE;
  assign bus.SC_GAMESTATUS_Lives_OutBUS  = lives;
  assign bus.SC_GAMESTATUS_Level_OutBUS  = level;
  assign bus.SC_GAMESTATUS_Houses_OutBUS = houses;

endmodule

// File: tb/tb_sc_gamestatus.sv
// Bench for sc_gamestatus: directed game scenarios followed by random strobes,
// all checked every cycle against a rule-level model of the game status.
module tb_sc_gamestatus;

  localparam int LIVES_INIT = 3;
  localparam int LEVEL_MAX  = 4;
  localparam int HOUSES     = 5;
  localparam int FULL       = (1 << HOUSES) - 1;

  localparam int M_IDLE = 0, M_PLAY = 1, M_PEND = 2, M_FROZEN = 3;

  logic clk;
  logic rstN;
  sc_gamestatus_if bus ();

  sc_gamestatus dut (
    .SC_GAMESTATUS_CLOCK_50    (clk),
    .SC_GAMESTATUS_RESET_InLow (rstN),
    .bus                       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state
  int mMode, mLives, mLevel, mHouses, mSlot;
  bit mLost, mArmed;

  task automatic chk(input string tag, input int got, input int expVal);
    nChecks++;
    if (got == expVal) nPass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, expVal, $time);
  endtask

  task automatic resetModel();
    mMode = M_IDLE; mLives = 0; mLevel = 0; mHouses = 0; mSlot = 0;
    mLost = 0; mArmed = 0;
  endtask

  task automatic applyModel();
    int frog;
    bit coll;
    frog = int'(bus.SC_GAMESTATUS_FrogTopRow_InBUS);
    coll = bus.SC_GAMESTATUS_Collision_InLow;
    if (!bus.SC_GAMESTATUS_StartGame_InLow) begin
      mLives = LIVES_INIT; mLevel = 0; mHouses = 0; mLost = 0; mArmed = 0; mMode = M_PLAY;
    end else if (!bus.SC_GAMESTATUS_ClearLost_InLow) begin
      mMode = M_FROZEN;
    end else if (!bus.SC_GAMESTATUS_LifesSignal_InLow) begin
      if (mMode != M_FROZEN) begin
        if (mLives > 0) mLives = mLives - 1;
        mLost = 0; mArmed = 0; mMode = M_PLAY;
      end
    end else if (!bus.SC_GAMESTATUS_LoadLastRegister_InLow) begin
      if (mMode == M_PEND) begin
        mHouses = mHouses | mSlot; mArmed = 0; mMode = M_PLAY;
      end
    end else if (!bus.SC_GAMESTATUS_LoadGame_InLow) begin
      if (mMode == M_PLAY && mHouses == FULL && mLevel < LEVEL_MAX) begin
        mLevel = mLevel + 1; mHouses = 0; mArmed = 0;
      end
    end else if (mMode == M_PLAY) begin
      if (!mArmed) begin
        if (frog == 0 && coll) mArmed = 1;
      end else if (!mLost) begin
        if (!coll) mLost = 1;
        else if ($countones(frog) == 1 && (frog & mHouses) == 0) begin
          mSlot = frog; mMode = M_PEND;
        end else if (frog != 0) mLost = 1;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    int expLast;
    expLast = (mHouses == FULL) ? 0 : (mMode == M_PEND) ? 2 : 1;
    chk({tag, ".matrix"}, int'(bus.SC_GAMESTATUS_MatrixComparator_OutLow), int'(!mLost));
    chk({tag, ".livesCmp"}, int'(bus.SC_GAMESTATUS_LifesCounterComparator_OutLow),
        int'(!(mMode != M_IDLE && mLives == 0)));
    chk({tag, ".levelCmp"}, int'(bus.SC_GAMESTATUS_LevelCounterComparator_OutLow),
        int'(mLevel != LEVEL_MAX));
    chk({tag, ".lastReg"}, int'(bus.SC_GAMESTATUS_LastRegister_OutBUS), expLast);
    chk({tag, ".lives"}, int'(bus.SC_GAMESTATUS_Lives_OutBUS), mLives);
    chk({tag, ".level"}, int'(bus.SC_GAMESTATUS_Level_OutBUS), mLevel);
    chk({tag, ".houses"}, int'(bus.SC_GAMESTATUS_Houses_OutBUS), mHouses);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rstN) applyModel();
    #1;
    checkAll(tag);
  endtask

  task automatic idleInputs();
    bus.SC_GAMESTATUS_StartGame_InLow        = 1'b1;
    bus.SC_GAMESTATUS_ClearLost_InLow        = 1'b1;
    bus.SC_GAMESTATUS_LifesSignal_InLow      = 1'b1;
    bus.SC_GAMESTATUS_LoadLastRegister_InLow = 1'b1;
    bus.SC_GAMESTATUS_LoadGame_InLow         = 1'b1;
    bus.SC_GAMESTATUS_Collision_InLow        = 1'b1;
    bus.SC_GAMESTATUS_FrogTopRow_InBUS       = '0;
  endtask

  task automatic pulseStart(input string tag);
    bus.SC_GAMESTATUS_StartGame_InLow = 1'b0; step(tag); bus.SC_GAMESTATUS_StartGame_InLow = 1'b1;
  endtask
  task automatic pulseLife(input string tag);
    bus.SC_GAMESTATUS_LifesSignal_InLow = 1'b0; step(tag); bus.SC_GAMESTATUS_LifesSignal_InLow = 1'b1;
  endtask
  task automatic pulseHouse(input string tag);
    bus.SC_GAMESTATUS_LoadLastRegister_InLow = 1'b0; step(tag);
    bus.SC_GAMESTATUS_LoadLastRegister_InLow = 1'b1;
  endtask
  task automatic pulseLevel(input string tag);
    bus.SC_GAMESTATUS_LoadGame_InLow = 1'b0; step(tag); bus.SC_GAMESTATUS_LoadGame_InLow = 1'b1;
  endtask

  task automatic fillHouses();
    for (int i = 0; i < HOUSES; i++) begin
      if (((mHouses >> i) & 1) == 0) begin
        bus.SC_GAMESTATUS_FrogTopRow_InBUS = '0;  step("fill.arm");
        bus.SC_GAMESTATUS_FrogTopRow_InBUS = HOUSES'(1 << i); step("fill.cap");
        pulseHouse("fill.load");
      end
    end
    bus.SC_GAMESTATUS_FrogTopRow_InBUS = '0;
  endtask

  initial begin
    int r;
    resetModel();
    idleInputs();
    rstN = 1'b0;

    // Reset state
    step("rst"); step("rst");
    chk("rst.lives", int'(bus.SC_GAMESTATUS_Lives_OutBUS), 0);
    chk("rst.lastReg", int'(bus.SC_GAMESTATUS_LastRegister_OutBUS), 1);
    chk("rst.livesCmp", int'(bus.SC_GAMESTATUS_LifesCounterComparator_OutLow), 1);
    rstN = 1'b1;

    // Start
    pulseStart("start");
    chk("start.lives", int'(bus.SC_GAMESTATUS_Lives_OutBUS), 3);
    chk("start.lastReg", int'(bus.SC_GAMESTATUS_LastRegister_OutBUS), 1);
    chk("start.matrix", int'(bus.SC_GAMESTATUS_MatrixComparator_OutLow), 1);

    // Life loss
    step("arm");
    bus.SC_GAMESTATUS_Collision_InLow = 1'b0; step("coll");
    bus.SC_GAMESTATUS_Collision_InLow = 1'b1;
    chk("coll.matrix", int'(bus.SC_GAMESTATUS_MatrixComparator_OutLow), 0);
    pulseLife("life1");
    chk("life1.lives", int'(bus.SC_GAMESTATUS_Lives_OutBUS), 2);
    chk("life1.matrix", int'(bus.SC_GAMESTATUS_MatrixComparator_OutLow), 1);
    for (int k = 0; k < 2; k++) begin
      step("arm");
      bus.SC_GAMESTATUS_Collision_InLow = 1'b0; step("coll");
      bus.SC_GAMESTATUS_Collision_InLow = 1'b1;
      pulseLife("lifeN");
    end
    chk("life3.lives", int'(bus.SC_GAMESTATUS_Lives_OutBUS), 0);
    chk("life3.livesCmp", int'(bus.SC_GAMESTATUS_LifesCounterComparator_OutLow), 0);
    pulseLife("life4");
    chk("life4.lives", int'(bus.SC_GAMESTATUS_Lives_OutBUS), 0);

    // House capture and rearm
    pulseStart("start2");
    step("arm");
    bus.SC_GAMESTATUS_FrogTopRow_InBUS = 5'b00100; step("cap");
    chk("cap.lastReg", int'(bus.SC_GAMESTATUS_LastRegister_OutBUS), 2);
    pulseHouse("load");
    chk("load.houses", int'(bus.SC_GAMESTATUS_Houses_OutBUS), 5'b00100);
    chk("load.lastReg", int'(bus.SC_GAMESTATUS_LastRegister_OutBUS), 1);
    step("hold"); step("hold");
    chk("hold.matrix", int'(bus.SC_GAMESTATUS_MatrixComparator_OutLow), 1);
    bus.SC_GAMESTATUS_FrogTopRow_InBUS = '0; step("rearm");
    bus.SC_GAMESTATUS_FrogTopRow_InBUS = 5'b00100; step("occupied");
    chk("occupied.matrix", int'(bus.SC_GAMESTATUS_MatrixComparator_OutLow), 0);
    bus.SC_GAMESTATUS_FrogTopRow_InBUS = '0;
    pulseLife("clearLost");

    // Level advance
    for (int lv = 1; lv <= LEVEL_MAX; lv++) begin
      fillHouses();
      chk("full.lastReg", int'(bus.SC_GAMESTATUS_LastRegister_OutBUS), 0);
      pulseLevel("adv");
      chk("adv.level", int'(bus.SC_GAMESTATUS_Level_OutBUS), lv);
      chk("adv.houses", int'(bus.SC_GAMESTATUS_Houses_OutBUS), 0);
    end
    chk("max.levelCmp", int'(bus.SC_GAMESTATUS_LevelCounterComparator_OutLow), 0);
    fillHouses();
    pulseLevel("advMax");
    chk("advMax.level", int'(bus.SC_GAMESTATUS_Level_OutBUS), 4);
    chk("advMax.lastReg", int'(bus.SC_GAMESTATUS_LastRegister_OutBUS), 0);

    // Simultaneous strobes
    pulseStart("start3");
    step("arm");
    bus.SC_GAMESTATUS_FrogTopRow_InBUS = 5'b00001; step("cap");
    bus.SC_GAMESTATUS_LifesSignal_InLow = 1'b0;
    bus.SC_GAMESTATUS_LoadLastRegister_InLow = 1'b0;
    step("both");
    idleInputs();
    chk("both.lives", int'(bus.SC_GAMESTATUS_Lives_OutBUS), 2);
    chk("both.houses", int'(bus.SC_GAMESTATUS_Houses_OutBUS), 0);

    // Freeze
    step("arm");
    bus.SC_GAMESTATUS_Collision_InLow = 1'b0; step("coll");
    bus.SC_GAMESTATUS_ClearLost_InLow = 1'b0; step("freeze");
    bus.SC_GAMESTATUS_ClearLost_InLow = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.SC_GAMESTATUS_Collision_InLow  = 1'($urandom_range(0, 1));
      bus.SC_GAMESTATUS_FrogTopRow_InBUS = HOUSES'($urandom);
      step("frozen");
    end
    chk("frozen.matrix", int'(bus.SC_GAMESTATUS_MatrixComparator_OutLow), 0);
    chk("frozen.lives", int'(bus.SC_GAMESTATUS_Lives_OutBUS), 2);
    idleInputs();
    pulseStart("start4");
    chk("start4.lives", int'(bus.SC_GAMESTATUS_Lives_OutBUS), 3);

    // Asynchronous reset while a house is pending
    step("arm");
    bus.SC_GAMESTATUS_FrogTopRow_InBUS = 5'b00010; step("cap");
    chk("pend.lastReg", int'(bus.SC_GAMESTATUS_LastRegister_OutBUS), 2);
    #2 rstN = 1'b0;
    #1;
    resetModel();
    chk("arst.lastReg", int'(bus.SC_GAMESTATUS_LastRegister_OutBUS), 1);
    chk("arst.lives", int'(bus.SC_GAMESTATUS_Lives_OutBUS), 0);
    checkAll("arst");
    idleInputs();
    step("rstHold"); step("rstHold");
    rstN = 1'b1;

    // Random phase
    for (int c = 0; c < 2500; c++) begin
      r = int'($urandom_range(0, 99));
      bus.SC_GAMESTATUS_StartGame_InLow        = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      bus.SC_GAMESTATUS_ClearLost_InLow        = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      bus.SC_GAMESTATUS_LifesSignal_InLow      = ($urandom_range(0, 99) < 5) ? 1'b0 : 1'b1;
      bus.SC_GAMESTATUS_LoadLastRegister_InLow = ($urandom_range(0, 99) < 8) ? 1'b0 : 1'b1;
      bus.SC_GAMESTATUS_LoadGame_InLow         = ($urandom_range(0, 99) < 8) ? 1'b0 : 1'b1;
      bus.SC_GAMESTATUS_Collision_InLow        = ($urandom_range(0, 99) < 15) ? 1'b0 : 1'b1;
      if (r < 50)      bus.SC_GAMESTATUS_FrogTopRow_InBUS = '0;
      else if (r < 90) bus.SC_GAMESTATUS_FrogTopRow_InBUS = HOUSES'(1 << $urandom_range(0, HOUSES - 1));
      else             bus.SC_GAMESTATUS_FrogTopRow_InBUS = HOUSES'($urandom);
      step("rnd");
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
